// File: rtl/approx_div_pkg.sv
// -----------------------------------------------------------------------------
// approx_div_pkg
// Shared definitions for the operand issue stage feeding the 16/8 approximate
// array divider.
//   DIV_XW / DIV_YW : dividend / divisor widths
//   div_entry_t     : one buffered operand pair plus its classification flags
//   div_classify    : returns {dz, ovf} for a dividend/divisor pair
// -----------------------------------------------------------------------------
package approx_div_pkg;

   localparam int DIV_XW = 16;
   localparam int DIV_YW = 8;

   typedef struct packed {
      logic [DIV_XW-1:0] x;
      logic [DIV_YW-1:0] y;
      logic              dz;
      logic              ovf;
   } div_entry_t;

   // The quotient fits in DIV_YW bits exactly when the upper half of the
   // dividend is strictly below the divisor, so overflow is a single
   // unsigned compare. A zero divisor is reported as dz only, never ovf.
   function automatic logic [1:0] div_classify(input logic [DIV_XW-1:0] x,
                                               input logic [DIV_YW-1:0] y);
      logic dz;
      logic ovf;
      dz  = (y == '0);
      ovf = !dz && (x[DIV_XW-1 -: DIV_YW] >= y);
      return {dz, ovf};
   endfunction

endpackage

// File: rtl/div_fifo.sv
// -----------------------------------------------------------------------------
// div_fifo
// Generic DEPTH-entry synchronous FIFO of div_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   wr_en      : write request, ignored while full
//   wr_data    : entry to write
//   rd_en      : read (pop) request, ignored while empty
//   rd_data    : head entry, driven straight from storage
//   count      : current occupancy
//   full/empty : occupancy flags derived from count
// Pointers carry one extra bit so they wrap naturally modulo 2*DEPTH.
// -----------------------------------------------------------------------------
module div_fifo
   import approx_div_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  div_entry_t               wr_data,
   input  logic                     rd_en,
   output div_entry_t               rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   div_entry_t    mem [DEPTH];
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/approx_div_issue.sv
// -----------------------------------------------------------------------------
// approx_div_issue
// Operand issue stage directly upstream of the 16/8 approximate array divider.
// Operand pairs arrive over valid/ready, are classified (divide-by-zero,
// quotient overflow) on entry, buffered in a small FIFO and presented from
// registered storage to the combinational array. Saturating counters record
// how many entries, dz entries and ovf entries have been consumed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in_ready depends on state only
//   in_x, in_y          : dividend, divisor
//   out_valid/out_ready : downstream handshake for the head entry
//   out_x, out_y        : head operands to the array
//   out_bin             : array borrow-in, tied low
//   out_dz, out_ovf     : head classification flags
//   clr_stats           : synchronous counter clear, dominates increments
//   cnt_ops/dz/ovf      : saturating pop statistics
// -----------------------------------------------------------------------------
module approx_div_issue
   import approx_div_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_x,
   input  logic [7:0]        in_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_x,
   output logic [7:0]        out_y,
   output logic              out_bin,
   output logic              out_dz,
   output logic              out_ovf,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  cnt_ops,
   output logic [CNT_W-1:0]  cnt_dz,
   output logic [CNT_W-1:0]  cnt_ovf
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             inc);
      if (inc && (c != '1)) begin
         return c + CNT_W'(1);
      end
      return c;
   endfunction

   div_entry_t               in_entry;
   div_entry_t               head;
   logic [1:0]               cls;
   logic                     push;
   logic                     pop;
   logic                     full;
   logic                     empty;
   // Occupancy is not needed by the issue logic; left visible for debug.
   logic [$clog2(DEPTH):0]   fifo_count_unused;

   assign cls = div_classify(in_x, in_y);

   always_comb begin
      in_entry     = '0;
      in_entry.x   = in_x;
      in_entry.y   = in_y;
      in_entry.dz  = cls[1];
      in_entry.ovf = cls[0];
   end

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Storage is only written on push, so don't-care operands presented with
   // in_valid low never reach the registers.
   div_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data (in_entry),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count_unused),
      .full    (full),
      .empty   (empty)
   );

   assign out_x   = head.x;
   assign out_y   = head.y;
   assign out_dz  = head.dz;
   assign out_ovf = head.ovf;
   assign out_bin = 1'b0;

   // Pop statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ops <= '0;
         cnt_dz  <= '0;
         cnt_ovf <= '0;
      end else if (clr_stats) begin
         cnt_ops <= '0;
         cnt_dz  <= '0;
         cnt_ovf <= '0;
      end else if (pop) begin
         cnt_ops <= sat_inc(cnt_ops, 1'b1);
         cnt_dz  <= sat_inc(cnt_dz, head.dz);
         cnt_ovf <= sat_inc(cnt_ovf, head.ovf);
      end
   end

endmodule

// File: tb/tb_approx_div_issue.sv
// -----------------------------------------------------------------------------
// tb_approx_div_issue
// Two instances share one stimulus stream: the default CNT_W=16 build and a
// CNT_W=4 build whose counters saturate quickly. A queue holds the expected
// entries; the monitor pops and compares whenever the DUT hands off an entry.
// -----------------------------------------------------------------------------
module tb_approx_div_issue;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_stats = 1'b0;
   logic [15:0] in_x = '0;
   logic [7:0]  in_y = '0;

   logic        in_ready_a, out_valid_a, out_bin_a, out_dz_a, out_ovf_a;
   logic [15:0] out_x_a;
   logic [7:0]  out_y_a;
   logic [15:0] cnt_ops_a, cnt_dz_a, cnt_ovf_a;

   logic        in_ready_b, out_valid_b, out_bin_b, out_dz_b, out_ovf_b;
   logic [15:0] out_x_b;
   logic [7:0]  out_y_b;
   logic [3:0]  cnt_ops_b, cnt_dz_b, cnt_ovf_b;

   always #5 clk = ~clk;

   approx_div_issue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_x(in_x), .in_y(in_y), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_x(out_x_a), .out_y(out_y_a), .out_bin(out_bin_a), .out_dz(out_dz_a),
      .out_ovf(out_ovf_a), .clr_stats(clr_stats), .cnt_ops(cnt_ops_a),
      .cnt_dz(cnt_dz_a), .cnt_ovf(cnt_ovf_a));

   approx_div_issue #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_x(in_x), .in_y(in_y), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_x(out_x_b), .out_y(out_y_b), .out_bin(out_bin_b), .out_dz(out_dz_b),
      .out_ovf(out_ovf_b), .clr_stats(clr_stats), .cnt_ops(cnt_ops_b),
      .cnt_dz(cnt_dz_b), .cnt_ovf(cnt_ovf_b));

   typedef struct {
      logic [15:0] x;
      logic [7:0]  y;
      bit          dz;
      bit          ovf;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ops_n   = 0;
   int   dz_n    = 0;
   int   ovf_n   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: divide-by-zero, or a true quotient wider than 8 bits.
   function automatic exp_t model(input logic [15:0] x, input logic [7:0] y);
      exp_t e;
      e.x   = x;
      e.y   = y;
      e.dz  = (y == 8'd0);
      e.ovf = 1'b0;
      if (!e.dz) begin
         e.ovf = ((int'(x) / int'(y)) > 255);
      end
      return e;
   endfunction

   function automatic int sat(input int n, input int w);
      int m;
      m = (1 << w) - 1;
      return (n > m) ? m : n;
   endfunction

   // Monitor: inputs are stable around the falling edge, so what is seen here
   // is exactly what the next rising edge will act on.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         ops_n = 0;
         dz_n  = 0;
         ovf_n = 0;
         chk("rst_out_valid", out_valid_a, 0);
         chk("rst_in_ready", in_ready_a, 1);
         chk("rst_cnt_ops", cnt_ops_a, 0);
      end else begin
         chk("out_valid", out_valid_a, sb.size() != 0);
         chk("in_ready", in_ready_a, sb.size() < DEPTH);
         chk("out_valid_w4", out_valid_b, sb.size() != 0);
         chk("out_bin", out_bin_a, 0);
         chk("cnt_ops", cnt_ops_a, sat(ops_n, 16));
         chk("cnt_dz", cnt_dz_a, sat(dz_n, 16));
         chk("cnt_ovf", cnt_ovf_a, sat(ovf_n, 16));
         chk("cnt_ops_w4", cnt_ops_b, sat(ops_n, 4));
         chk("cnt_dz_w4", cnt_dz_b, sat(dz_n, 4));
         chk("cnt_ovf_w4", cnt_ovf_b, sat(ovf_n, 4));
         if (out_valid_a && out_ready) begin
            if (sb.size() == 0) begin
               chk("pop_without_entry", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out_x", out_x_a, e.x);
               chk("out_y", out_y_a, e.y);
               chk("out_dz", out_dz_a, e.dz);
               chk("out_ovf", out_ovf_a, e.ovf);
               chk("out_x_w4", out_x_b, e.x);
               chk("out_dz_w4", out_dz_b, e.dz);
               if (!clr_stats) begin
                  ops_n++;
                  dz_n  += int'(e.dz);
                  ovf_n += int'(e.ovf);
               end
            end
         end
         if (clr_stats) begin
            ops_n = 0;
            dz_n  = 0;
            ovf_n = 0;
         end
         if (in_valid && in_ready_a) begin
            sb.push_back(model(in_x, in_y));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] x, input logic [7:0] y,
                        input logic r, input logic c);
      in_valid  = v;
      in_x      = x;
      in_y      = y;
      out_ready = r;
      clr_stats = c;
      step();
   endtask

   task automatic rnd_pair(output logic [15:0] x, output logic [7:0] y);
      x = 16'($urandom);
      y = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
   endtask

   initial begin
      logic [15:0] rx;
      logic [7:0]  ry;
      logic [15:0] base_ops;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_out_x", out_x_a, 0);
      chk("reset_out_y", out_y_a, 0);
      chk("reset_out_dz", out_dz_a, 0);
      chk("reset_out_ovf", out_ovf_a, 0);
      chk("reset_out_valid", out_valid_a, 0);
      chk("reset_in_ready", in_ready_a, 1);

      // single transfer, one-cycle latency
      drive(1, 16'h0F00, 8'h10, 0, 0);
      chk("t1_valid", out_valid_a, 1);
      chk("t1_x", out_x_a, 16'h0F00);
      chk("t1_y", out_y_a, 8'h10);
      chk("t1_dz", out_dz_a, 0);
      chk("t1_ovf", out_ovf_a, 0);
      drive(0, 16'hxxxx, 8'hxx, 1, 0);
      chk("t1_cnt_ops", cnt_ops_a, 1);

      // dz then ovf boundary (8'h20 >= 8'h20)
      drive(1, 16'h1234, 8'h00, 0, 0);
      drive(1, 16'h2000, 8'h20, 0, 0);
      chk("t2_head_dz", out_dz_a, 1);
      chk("t2_head_ovf", out_ovf_a, 0);
      drive(0, 16'h0, 8'h0, 1, 0);
      chk("t2_second_ovf", out_ovf_a, 1);
      chk("t2_second_dz", out_dz_a, 0);
      drive(0, 16'h0, 8'h0, 1, 0);
      chk("t2_cnt_dz", cnt_dz_a, 1);
      chk("t2_cnt_ovf", cnt_ovf_a, 1);

      // fill, stall, single-cycle drain, wrap-around order
      drive(1, 16'hA001, 8'h01, 0, 0);
      drive(1, 16'h00B2, 8'h02, 0, 0);
      chk("t3_full_ready", in_ready_a, 0);
      drive(1, 16'h0C03, 8'h7F, 0, 0);
      chk("t3_stalled_ready", in_ready_a, 0);
      drive(1, 16'h0C03, 8'h7F, 1, 0);
      chk("t3_freed_ready", in_ready_a, 1);
      drive(1, 16'h0C03, 8'h7F, 0, 0);
      for (int i = 0; i < 8; i++) begin
         rnd_pair(rx, ry);
         drive(1, rx, ry, 1, 0);
      end
      repeat (3) drive(0, 16'h0, 8'h0, 1, 0);

      // streaming: one transfer per cycle after the first
      base_ops = cnt_ops_a;
      for (int i = 0; i < 20; i++) begin
         rnd_pair(rx, ry);
         drive(1, rx, ry, 1, 0);
      end
      chk("t4_stream_ops", cnt_ops_a - base_ops, 19);

      // narrow counters saturate, then clear wins over a coincident pop
      for (int i = 0; i < 20; i++) begin
         rnd_pair(rx, ry);
         drive(1, rx, ry, 1, 0);
      end
      chk("t5_sat_ops_w4", cnt_ops_b, 15);
      rnd_pair(rx, ry);
      drive(1, rx, ry, 1, 1);
      chk("t5_clr_ops_w4", cnt_ops_b, 0);
      chk("t5_clr_ops", cnt_ops_a, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rnd_pair(rx, ry);
         drive(logic'($urandom_range(0, 3) != 0), rx, ry,
               logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 63) == 0));
      end

      // asynchronous reset with two entries buffered
      drive(0, 16'h0, 8'h0, 1, 0);
      drive(0, 16'h0, 8'h0, 1, 0);
      drive(1, 16'h5501, 8'h03, 0, 0);
      drive(1, 16'h6602, 8'h00, 0, 0);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t6_async_valid", out_valid_a, 0);
      chk("t6_async_ready", in_ready_a, 1);
      chk("t6_async_cnt", cnt_ops_a, 0);
      step();
      step();
      rst_n = 1'b1;
      repeat (3) drive(0, 16'h0, 8'h0, 1, 0);
      chk("t6_no_stale", out_valid_a, 0);
      for (int i = 0; i < 40; i++) begin
         rnd_pair(rx, ry);
         drive(logic'($urandom_range(0, 1)), rx, ry, logic'($urandom_range(0, 1)), 0);
      end
      repeat (4) drive(0, 16'h0, 8'h0, 1, 0);
      chk("final_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_div_issue.md
Name: approx_div_issue

Overview:
- Operand issue stage directly upstream of the 16/8 approximate array divider.
- Accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a small FIFO.
- Classifies each pair as divide-by-zero or quotient-overflow at enqueue, then presents registered operands, borrow-in and flags to the combinational array.
- Keeps saturating event counters for error-characterisation runs.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  stage can accept a pair
- in_x  in  16  dividend
- in_y  in  8  divisor
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_x  out  16  dividend to array x
- out_y  out  8  divisor to array y
- out_bin  out  1  borrow-in to array; constant 0
- out_dz  out  1  head entry has y==0
- out_ovf  out  1  head entry quotient exceeds 8 bits
- clr_stats  in  1  synchronous counter clear pulse
- cnt_ops  out  CNT_W  entries popped
- cnt_dz  out  CNT_W  popped entries with dz
- cnt_ovf  out  CNT_W  popped entries with ovf

Behaviour:
- Single clock domain; all state on posedge clk; rst_n is asynchronous assert, synchronous deassert externally guaranteed.
- Reset values:
  - wr_ptr=rd_ptr=0 and count=0, so out_valid=0 and in_ready=1.
  - All three counters 0.
  - FIFO storage cleared to 0, so out_x=0, out_y=0, out_dz=0, out_ovf=0.
  - out_bin=0 always.
- FIFO pointers are log2(DEPTH)+1 bits. Wrap-around is natural modulo 2*DEPTH. full = count==DEPTH; empty = count==0.
- in_ready = !full. It is registered-state derived only and has no combinational path from out_ready.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- out_valid = !empty. out_x, out_y, out_dz and out_ovf are driven from the head entry (storage registers, no combinational logic from in_*).
- Latency: a pair pushed in cycle N is visible with out_valid=1 in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop:
  - Allowed when neither full nor empty; count unchanged.
  - When empty, only the push occurs because out_valid=0.
  - When full, only the pop occurs because in_ready=0; the freed slot is offered from the next cycle.
- Classification is computed at push and stored with the entry:
  - dz = (in_y==0).
  - ovf = !dz && (in_x[15:8] >= in_y). Unsigned compare, 8-bit.
  - dz and ovf are mutually exclusive.
- Head stability: while out_valid && !out_ready, the head outputs are stable.
- Counters update on each pop:
  - cnt_ops += 1; cnt_dz += out_dz; cnt_ovf += out_ovf.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - clr_stats sets all counters to 0 that cycle; clear wins over a coincident increment.
- Reset mid-operation: all buffered entries are discarded and counters zeroed. No partial pop is reported.
- in_x and in_y are don't-care when in_valid=0. X on these does not propagate into storage.

Decomposition:
- Shared package approx_div_pkg holds:
  - DIV_XW=16 and DIV_YW=8.
  - A packed struct div_entry_t {x[15:0], y[7:0], dz, ovf}.
  - A function div_classify(x,y) returning {dz,ovf}.
- One sub-module, div_fifo. It is a generic DEPTH-entry synchronous FIFO of div_entry_t with count, full and empty. The top holds the classifier and counters.

Test Plan:
- Reset then push x=16'h0F00, y=8'h10 -> next cycle out_valid=1, out_x=16'h0F00, out_y=8'h10, dz=0, ovf=0; pop with out_ready=1 -> cnt_ops=1.
- Push y=8'h00 then x=16'h2000, y=8'h20 -> first head dz=1, ovf=0; second head ovf=1, dz=0 (8'h20>=8'h20); after both pops cnt_dz=1, cnt_ovf=1.
- Hold out_ready=0 and push 3 pairs with DEPTH=2 -> in_ready=0 after the 2nd push and the 3rd is stalled; assert out_ready for 1 cycle -> in_ready returns to 1 the next cycle. FIFO order is preserved over 8 subsequent wrap-around transfers.
- Run streaming with in_valid=out_ready=1 for 20 cycles -> one transfer per cycle after the first, count stays 1, cnt_ops=19 after cycle 20.
- Preload cnt_ops near saturation by forcing CNT_W=4: pop 20 entries -> cnt_ops holds 15. Pulse clr_stats together with a pop -> cnt_ops=0.
- Assert rst_n=0 mid-stream with 2 entries buffered -> out_valid=0 and in_ready=1 immediately (asynchronously), all counters 0, and no stale entry appears after release.
